mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Clocked initiator for the 8x8 NAND-latch memory unit. It converts single-cycle valid/ready requests into the unit's op/select/address/in_bus signalling with safe setup, strobe and hold phases. It captures out_bus for reads. After every reset it flushes all words to zero, so the latch array never holds undefined data.

Parameters:
ADDR_W, 3, memory address width
DATA_W, 8, data bus width
DEPTH, 8, number of words (2**ADDR_W); words flushed after reset
HOLD_CYCLES, 2, cycles mem_select is held high per access (>=1)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1=write, 0=read
req_addr  input  ADDR_W  target word
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse: access complete
rsp_data  output  DATA_W  read data, valid when rsp_valid after a read
init_done  output  1  flush finished
mem_op  output  1  to memory op (1=write, 0=read)
mem_select  output  1  to memory select
mem_address  output  ADDR_W  to memory address
mem_in_bus  output  DATA_W  to memory in_bus
mem_out_bus  input  DATA_W  from memory out_bus

Behaviour:
- Reset values: all outputs 0, including mem_select, mem_op, mem_address, mem_in_bus, req_ready, rsp_valid, rsp_data and init_done. The FSM enters FLUSH_SETUP with the flush index at 0.
- Reset asserted mid-access: the next edge applies the reset values, so mem_select drops there. The flush then restarts from address 0.
- All mem_* and rsp_* outputs are registered.
- States: FLUSH_SETUP, FLUSH_STROBE, FLUSH_RELEASE, IDLE, SETUP, STROBE, RELEASE.
- Access sequence, used by both flush and normal accesses:
  - SETUP, 1 cycle: mem_address, mem_op and mem_in_bus are driven; mem_select=0.
  - STROBE, HOLD_CYCLES cycles: mem_select=1; address, op and data are unchanged.
  - RELEASE, 1 cycle: mem_select=0; address, op and data are still unchanged.
- Flush:
  - Performs writes of 0 (mem_op=1, mem_in_bus=0) to addresses 0..DEPTH-1 in order.
  - Takes DEPTH*(HOLD_CYCLES+2) cycles.
  - No rsp_valid pulses during flush.
  - After the last RELEASE: init_done=1 (sticky until reset) and state goes to IDLE.
- Handshake:
  - req_ready=1 only in IDLE with init_done=1.
  - A request is accepted on the edge where req_valid && req_ready.
  - req_we, req_addr and req_wdata are latched on that edge; later changes have no effect.
  - The next cycle is SETUP and req_ready=0.
  - Requests presented while req_ready=0 are ignored, not queued.
- Reads:
  - mem_op=0 and mem_in_bus=0.
  - mem_out_bus is sampled into rsp_data at the edge ending the last STROBE cycle.
- RELEASE cycle: rsp_valid=1 for exactly one cycle, for both reads and writes. rsp_data is updated only by reads and holds its last value after writes.
- Latency, with the accept edge as cycle 0:
  - SETUP is cycle 1.
  - STROBE is cycles 2..HOLD_CYCLES+1.
  - RELEASE/rsp_valid is cycle HOLD_CYCLES+2.
  - IDLE (req_ready=1) is cycle HOLD_CYCLES+3.
  - With the default HOLD_CYCLES=2, rsp_valid is in cycle 4 and the maximum throughput is one access per 5 cycles.
- Back-to-back requests: a request held valid through completion is accepted again on the first IDLE cycle.
- Address wrap: the flush index runs 0..DEPTH-1 and does not wrap. req_addr is used unmodified.
- Strobe counter: ceil(log2(HOLD_CYCLES+1)) bits, reloaded in SETUP.

Test Plan:
- Reset 1 cycle then release -> 8 flush writes with data 0x00 at addresses 0..7, each with select high for exactly 2 cycles. The memory model then holds all zeros; init_done=1 and req_ready=1 at cycle 33 after reset.
- Write 0x55 to addr 0 -> mem_address/mem_in_bus stable from 1 cycle before select rises to 1 cycle after it falls, mem_op=1. rsp_valid is a single pulse 4 cycles after accept.
- Read addr 0 -> mem_op=0, mem_in_bus=0x00, rsp_valid 4 cycles after accept with rsp_data=0x55.
- Write 0xF0 to addr 4, then read addr 4 and addr 0 back-to-back with req_valid held high -> rsp_data is 0xF0 then 0x55. The second request is accepted exactly 5 cycles after the first, and no request is accepted while busy.
- Assert rst during STROBE of a write of 0xAA to addr 7 -> mem_select=0 on the next edge and the flush reruns. A later read of addr 7 returns 0x00.
- HOLD_CYCLES=1 build -> select high for 1 cycle per access, rsp_valid 3 cycles after accept, flush takes 24 cycles.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Clocked initiator for the NAND-latch memory unit: zero-flushes every word after reset,
// then serves valid/ready accesses with setup, strobe and release phases on the mem_* bus.
module mem_access_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_bus,
  input  logic [DATA_W-1:0] mem_out_bus
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    FLUSH_SETUP, FLUSH_STROBE, FLUSH_RELEASE, IDLE, SETUP, STROBE, RELEASE
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ADDR_W-1:0] flush_idx, idx_next;
  logic              accept;
  logic              op_next, select_next, rsp_valid_next, done_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] in_next, data_next;

  assign req_ready = (state == IDLE) && init_done;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FLUSH_SETUP;
      cnt         <= '0;
      flush_idx   <= '0;
      mem_op      <= 1'b0;
      mem_select  <= 1'b0;
      mem_address <= '0;
      mem_in_bus  <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      init_done   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      flush_idx   <= idx_next;
      mem_op      <= op_next;
      mem_select  <= select_next;
      mem_address <= addr_next;
      mem_in_bus  <= in_next;
      rsp_valid   <= rsp_valid_next;
      rsp_data    <= data_next;
      init_done   <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = flush_idx;
    case (state)
      FLUSH_SETUP: begin
        state_next = FLUSH_STROBE;
        cnt_next   = CNT_LOAD;
      end
      FLUSH_STROBE: begin
        if (cnt == '0) state_next = FLUSH_RELEASE;
        else           cnt_next   = cnt - 1'b1;
      end
      FLUSH_RELEASE: begin
        if (flush_idx == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          state_next = FLUSH_SETUP;
          idx_next   = flush_idx + 1'b1;
        end
      end
      IDLE: begin
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        state_next = STROBE;
        cnt_next   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt == '0) state_next = RELEASE;
        else           cnt_next   = cnt - 1'b1;
      end
      RELEASE:  state_next = IDLE;
      default:  state_next = FLUSH_SETUP;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  // The first flush setup after reset still shows the reset value mem_op=0;
  // op is raised together with select so word 0 is written rather than read.
  always_comb begin
    op_next        = mem_op;
    addr_next      = mem_address;
    in_next        = mem_in_bus;
    data_next      = rsp_data;
    done_next      = init_done;
    select_next    = (state_next == FLUSH_STROBE) || (state_next == STROBE);
    rsp_valid_next = (state_next == RELEASE);
    if (state_next inside {FLUSH_SETUP, FLUSH_STROBE, FLUSH_RELEASE}) begin
      op_next   = 1'b1;
      addr_next = idx_next;
      in_next   = '0;
    end
    if (accept) begin
      op_next   = req_we;
      addr_next = req_addr;
      in_next   = req_we ? req_wdata : '0;
    end
    if (state == STROBE && state_next == RELEASE && !mem_op)
      data_next = mem_out_bus;
    if (state == FLUSH_RELEASE && state_next == IDLE)
      done_next = 1'b1;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a behavioural memory plus reference model predict
// bus transactions and responses; monitors compare them as the DUT presents them.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int HOLD   = 2;
  localparam int HOLD_B = 1;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] data;
    int                due;
  } rsp_t;

  typedef struct {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } bus_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT A: default build
  logic              rst, req_valid, req_ready, req_we, rsp_valid, init_done;
  logic              mem_op, mem_select;
  logic [ADDR_W-1:0] req_addr, mem_address;
  logic [DATA_W-1:0] req_wdata, rsp_data, mem_in_bus, mem_out_bus;

  // DUT B: HOLD_CYCLES=1 build
  logic              rst_b, req_valid_b, req_ready_b, req_we_b, rsp_valid_b, init_done_b;
  logic              mem_op_b, mem_select_b;
  logic [ADDR_W-1:0] req_addr_b, mem_address_b;
  logic [DATA_W-1:0] req_wdata_b, rsp_data_b, mem_in_bus_b, mem_out_bus_b;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .init_done(init_done), .mem_op(mem_op), .mem_select(mem_select),
    .mem_address(mem_address), .mem_in_bus(mem_in_bus), .mem_out_bus(mem_out_bus)
  );

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD_B)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .init_done(init_done_b), .mem_op(mem_op_b), .mem_select(mem_select_b),
    .mem_address(mem_address_b), .mem_in_bus(mem_in_bus_b), .mem_out_bus(mem_out_bus_b)
  );

  // Latch-array models; start filled with garbage so the flush is observable
  logic              garbage = 1'b1;
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  always @(posedge clk) begin
    if (garbage) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= DATA_W'($urandom);
        mem_b[i] <= DATA_W'($urandom);
      end
    end else begin
      if (mem_select === 1'b1 && mem_op === 1'b1) mem_a[mem_address] <= mem_in_bus;
      if (mem_select_b === 1'b1 && mem_op_b === 1'b1) mem_b[mem_address_b] <= mem_in_bus_b;
    end
  end

  assign mem_out_bus   = (mem_select === 1'b1) ? mem_a[mem_address] : '0;
  assign mem_out_bus_b = (mem_select_b === 1'b1) ? mem_b[mem_address_b] : '0;

  // Reference model and scoreboards
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] last_rd;
  rsp_t              rsp_q[$];
  bus_t              bus_q[$];
  logic              aborting = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int t0;
    rst = 1'b1;
    step();
    check({mem_select, mem_op, mem_address, mem_in_bus, req_ready, rsp_valid, rsp_data, init_done} === '0,
          "reset_values",
          {mem_select, mem_op, mem_address, mem_in_bus, req_ready, rsp_valid, rsp_data, init_done}, 0);
    rst = 1'b0;
    rsp_q.delete();
    bus_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      bus_t b;
      b.op = 1'b1; b.addr = ADDR_W'(i); b.din = '0;
      bus_q.push_back(b);
      ref_mem[i] = '0;
    end
    last_rd = '0;
    t0 = cyc;
    step();
    aborting = 1'b0;
    while (init_done !== 1'b1 && (cyc - t0) < 200) step();
    check(cyc - t0 == DEPTH * (HOLD + 2), "flush_cycles", cyc - t0, DEPTH * (HOLD + 2));
    check(req_ready === 1'b1, "ready_after_flush", req_ready, 1);
    for (int i = 0; i < DEPTH; i++)
      check(mem_a[i] === '0, "flushed_word", mem_a[i], 0);
  endtask

  // Presents a request and returns just after its accept edge with req_valid still high
  task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       output int acc);
    int unsigned w = 0;
    rsp_t r;
    bus_t b;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (req_ready !== 1'b1 && w < 64) begin step(); w++; end
    if (req_ready !== 1'b1) begin
      check(1'b0, "accept_timeout", w, 64);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (!we) last_rd = ref_mem[a];
    r.we = we; r.data = last_rd; r.due = cyc + HOLD + 2;
    rsp_q.push_back(r);
    b.op = we; b.addr = a; b.din = we ? d : '0;
    bus_q.push_back(b);
    if (we) ref_mem[a] = d;
    step();
  endtask

  // Drives random junk requests while busy; none of them may be taken
  task automatic spam();
    int unsigned w = 0;
    while (req_ready !== 1'b1 && w < 64) begin
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = ADDR_W'($urandom);
      req_wdata = DATA_W'($urandom);
      step();
      w++;
    end
    req_valid = 1'b0;
  endtask

  task automatic b_access(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] exp);
    int unsigned w = 0;
    int p;
    req_valid_b = 1'b1; req_we_b = we; req_addr_b = a; req_wdata_b = d;
    while (req_ready_b !== 1'b1 && w < 64) begin step(); w++; end
    p = cyc;
    step();
    req_valid_b = 1'b0;
    w = 0;
    while (rsp_valid_b !== 1'b1 && w < 64) begin step(); w++; end
    check(cyc - p == HOLD_B + 2, "b_rsp_latency", cyc - p, HOLD_B + 2);
    check(rsp_data_b === exp, "b_rsp_data", rsp_data_b, exp);
  endtask

  // Response monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) begin
          check(1'b0, "rsp_spurious", 1, 0);
        end else begin
          r = rsp_q.pop_front();
          check(cyc == r.due, "rsp_latency", cyc, r.due);
          check(rsp_data === r.data, "rsp_data", rsp_data, r.data);
        end
      end
    end
  end

  // Memory-bus monitor: fields, setup/hold stability and strobe width
  logic              sp = 1'b0;
  logic              op_p;
  logic [ADDR_W-1:0] ad_p;
  logic [DATA_W-1:0] in_p;
  int                hi = 0;

  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      if (mem_select === 1'b1 && !sp) begin
        if (bus_q.size() == 0) begin
          check(1'b0, "bus_unexpected", mem_address, 0);
        end else begin
          b = bus_q.pop_front();
          check({mem_op, mem_address, mem_in_bus} === {b.op, b.addr, b.din}, "bus_fields",
                {mem_op, mem_address, mem_in_bus}, {b.op, b.addr, b.din});
        end
        check({mem_address, mem_in_bus} === {ad_p, in_p}, "bus_setup",
              {mem_address, mem_in_bus}, {ad_p, in_p});
        if (init_done === 1'b1) check(mem_op === op_p, "op_setup", mem_op, op_p);
        hi = 1;
      end else if (mem_select === 1'b1) begin
        check({mem_op, mem_address, mem_in_bus} === {op_p, ad_p, in_p}, "bus_hold",
              {mem_op, mem_address, mem_in_bus}, {op_p, ad_p, in_p});
        hi++;
      end else if (sp && !aborting) begin
        check(hi == HOLD, "select_width", hi, HOLD);
        check({mem_op, mem_address, mem_in_bus} === {op_p, ad_p, in_p}, "bus_release",
              {mem_op, mem_address, mem_in_bus}, {op_p, ad_p, in_p});
      end
      sp   = (mem_select === 1'b1);
      op_p = mem_op;
      ad_p = mem_address;
      in_p = mem_in_bus;
    end
  end

  // Strobe-width monitor for the HOLD_CYCLES=1 build
  int hi_b = 0;
  int falls_b = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_select_b === 1'b1) begin
        hi_b++;
      end else if (hi_b != 0) begin
        check(hi_b == HOLD_B, "b_select_width", hi_b, HOLD_B);
        falls_b++;
        hi_b = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2, a3, mode, t0;
    int unsigned w;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rst_b = 1'b1; req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
    step();
    garbage = 1'b0;
    do_reset();

    issue(1'b1, 3'd0, 8'h55, a1); spam();
    issue(1'b0, 3'd0, 8'h00, a1); spam();

    issue(1'b1, 3'd4, 8'hF0, a1);
    issue(1'b0, 3'd4, 8'h00, a2);
    issue(1'b0, 3'd0, 8'h00, a3);
    spam();
    check(a2 - a1 == HOLD + 3, "b2b_gap_1", a2 - a1, HOLD + 3);
    check(a3 - a2 == HOLD + 3, "b2b_gap_2", a3 - a2, HOLD + 3);

    // Reset in the middle of a strobe: select must drop and the flush rerun
    issue(1'b1, 3'd7, 8'hAA, a1);
    req_valid = 1'b0;
    step();
    check(mem_select === 1'b1, "strobe_reached", mem_select, 1);
    aborting = 1'b1;
    do_reset();
    issue(1'b0, 3'd7, 8'h00, a1); spam();

    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom);
      a  = ADDR_W'($urandom);
      d  = DATA_W'($urandom);
      issue(we, a, d, a1);
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        spam();
      end else if (mode == 2) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 6)) step();
      end
    end
    spam();

    w = 0;
    while (rsp_q.size() != 0 && w < 100) begin step(); w++; end
    step(); step();
    check(rsp_q.size() == 0, "rsp_drain", rsp_q.size(), 0);
    check(bus_q.size() == 0, "bus_drain", bus_q.size(), 0);

    rst_b = 1'b0;
    t0 = cyc;
    while (init_done_b !== 1'b1 && (cyc - t0) < 200) step();
    check(cyc - t0 == DEPTH * (HOLD_B + 2), "b_flush_cycles", cyc - t0, DEPTH * (HOLD_B + 2));
    b_access(1'b1, 3'd2, 8'h3C, 8'h00);
    b_access(1'b0, 3'd2, 8'h00, 8'h3C);
    step(); step();
    check(falls_b == DEPTH + 2, "b_strobes", falls_b, DEPTH + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
